pulp_clock_div_ctrl: RTL

- Multi-channel, programmable clock-enable divider for the clock-cell library.
- Generates one enable stream per channel (en_o[c] high 1 of every DIV+1 cycles) to drive the en_i of a downstream integrated clock-gating cell.
- Configured per channel over a valid/ready port; ratio and enable changes take effect only at a period boundary, so no truncated or merged enable periods occur.
- Sits between the SoC clock/power control registers and the ICG array.

---
 rtl/pulp_clock_div_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/pulp_clock_div_ctrl.sv
// pulp_clock_div_ctrl: per-channel programmable clock-enable divider.
// Optional phase-align via sync_i when PULP_CLOCK_DIV_CTRL_SYNC_EN is defined.
module pulp_clock_div_ctrl #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic              cfg_en_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] en_o,
  output logic [NUM_CH-1:0] pend_o
);

  typedef struct packed {
    logic             en;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic             pend;
    logic [DIV_W-1:0] pdiv;
    logic             pen;
  } ch_t;

  logic [NUM_CH-1:0] sel;
  logic              pend_sel;
  logic              xfer;
  logic              sync;

`ifdef PULP_CLOCK_DIV_CTRL_SYNC_EN
  assign sync = sync_i;
`else
  logic unused_sync;
  assign unused_sync = sync_i;
  assign sync = 1'b0;
`endif

  // out-of-range channel selects nothing, so it is always ready
  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c] = (cfg_ch_i == CH_W'(c));
    end
  end

  assign pend_sel    = |(sel & pend_o);
  assign cfg_ready_o = ~rst_i & ~pend_sel;
  assign xfer        = cfg_valid_i & cfg_ready_o;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_t  q;
    logic hit;
    logic wrap;

    assign hit  = xfer & sel[c];
    assign wrap = q.en & ((q.cnt == q.div) | sync);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        q <= '0;
      end else begin
        if (hit & ~q.en) begin
          q.en  <= cfg_en_i;
          q.div <= cfg_div_i;
          q.cnt <= '0;
        end else if (wrap) begin
          q.cnt <= '0;
          if (q.pend) begin
            q.en   <= q.pen;
            q.div  <= q.pdiv;
            q.pend <= 1'b0;
          end
        end else if (q.en) begin
          q.cnt <= q.cnt + DIV_W'(1);
        end
        // ready excludes pending channels, so this never meets an apply
        if (hit & q.en) begin
          q.pend <= 1'b1;
          q.pdiv <= cfg_div_i;
          q.pen  <= cfg_en_i;
        end
      end
    end

    assign en_o[c]   = test_en_i | (q.en & (q.cnt == q.div));
    assign pend_o[c] = q.pend;
  end

endmodule
